// File: rtl/cpu_step_ctrl.sv
// Execution controller for the single-cycle core: single-step, fixed-rate run and halt,
// plus a saturating executed-instruction counter. Define BREAKPOINT_EN to add PC breakpoints.
module cpu_step_ctrl #(
    parameter int CLK_HZ = 50_000_000,
    parameter int RUN_HZ = 10,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_pulse,
    input  logic              run_pulse,
    input  logic              halt_in,
`ifdef BREAKPOINT_EN
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_valid,
    output logic              bp_hit,
`endif
    output logic              cpu_en,
    output logic              running,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int DIV   = CLK_HZ / RUN_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    if (DIV < 2 || ADDR_W < 1) begin : g_param_check
        $error("cpu_step_ctrl: CLK_HZ/RUN_HZ must be >= 2 and ADDR_W >= 1");
    end

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        STEP   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_e;

    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic             cpu_en_q;
    logic             running_q;
    logic             halted_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             run_due;
`ifdef BREAKPOINT_EN
    logic             bp_hit_q;
    logic             bp_match;

    assign bp_match = bp_valid && (pc == bp_addr);
`endif

    // The count advances once per issued enable and sticks at all-ones.
    always_comb begin
        count_d = count_q;
        if (cpu_en_q && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    assign run_due = (div_q == DIV_LAST);

    // NOTE: all state lives in this one clocked block and uses non-blocking assignments,
    // so every branch reads the pre-edge values and the assignment order cannot race.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PAUSED;
            div_q     <= '0;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            count_q   <= '0;
`ifdef BREAKPOINT_EN
            bp_hit_q  <= 1'b0;
`endif
        end else begin
            cpu_en_q <= 1'b0;
            count_q  <= count_d;
`ifdef BREAKPOINT_EN
            bp_hit_q <= 1'b0;
`endif
            if (halt_in && (state_q != HALTED)) begin
                state_q   <= HALTED;
                div_q     <= '0;
                running_q <= 1'b0;
                halted_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    PAUSED: begin
                        if (run_pulse) begin
                            state_q   <= RUN;
                            div_q     <= '0;
                            running_q <= 1'b1;
                        end else if (step_pulse) begin
                            state_q  <= STEP;
                            cpu_en_q <= 1'b1;
                        end
                    end
                    STEP: begin
                        state_q <= PAUSED;
                    end
                    RUN: begin
                        if (run_pulse) begin
                            state_q   <= PAUSED;
                            div_q     <= '0;
                            running_q <= 1'b0;
                        end else if (run_due) begin
                            div_q <= '0;
`ifdef BREAKPOINT_EN
                            if (bp_match) begin
                                state_q   <= PAUSED;
                                running_q <= 1'b0;
                                bp_hit_q  <= 1'b1;
                            end else begin
                                cpu_en_q <= 1'b1;
                            end
`else
                            cpu_en_q <= 1'b1;
`endif
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end
                    HALTED: begin
                        // Only reset leaves HALTED.
                        state_q <= HALTED;
                    end
                    default: begin
                        state_q <= PAUSED;
                    end
                endcase
            end
        end
    end

    assign cpu_en      = cpu_en_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign instr_count = count_q;
`ifdef BREAKPOINT_EN
    assign bp_hit      = bp_hit_q;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DIV=10 and a 2-bit counter so saturation is reachable.
module tb_cpu_step_ctrl;

    localparam int CNT_W  = 2;
    localparam int ADDR_W = 8;

    logic             clk;
    logic             reset;
    logic             step_pulse;
    logic             run_pulse;
    logic             halt_in;
    logic             cpu_en;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] instr_count;
`ifdef BREAKPOINT_EN
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_valid;
    logic              bp_hit;
`endif

    int errors = 0;
    int checks = 0;

    cpu_step_ctrl #(
        .CLK_HZ(100),
        .RUN_HZ(10),
        .CNT_W (CNT_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step_pulse (step_pulse),
        .run_pulse  (run_pulse),
        .halt_in    (halt_in),
`ifdef BREAKPOINT_EN
        .pc         (pc),
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
        .bp_hit     (bp_hit),
`endif
        .cpu_en     (cpu_en),
        .running    (running),
        .halted     (halted),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cpu_en, running, halted, instr_count} !== '0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=0", {cpu_en, running, halted, instr_count});
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if ({cpu_en, running, halted, instr_count} !== '0) begin
                errors++;
                $display("FAIL idle_cycle_%0d got=%b exp=0", i, {cpu_en, running, halted, instr_count});
            end
        end
    endtask

    task automatic test_single_step();
        for (int s = 1; s <= 3; s++) begin
            step_pulse = 1'b1;
            tick();
            step_pulse = 1'b0;
            checks++;
            if (cpu_en !== 1'b1) begin
                errors++;
                $display("FAIL step%0d_en got=%b exp=1", s, cpu_en);
            end
            tick();
            checks++;
            if (cpu_en !== 1'b0 || instr_count !== CNT_W'(s)) begin
                errors++;
                $display("FAIL step%0d_after got en=%b cnt=%0d exp en=0 cnt=%0d", s, cpu_en, instr_count, s);
            end
            repeat (4) tick();
        end
        // A second pulse arriving while in STEP is ignored.
        do_reset();
        step_pulse = 1'b1;
        tick();
        tick();
        step_pulse = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cpu_en !== 1'b0) begin
                errors++;
                $display("FAIL step_ignored_%0d got en=%b exp=0", i, cpu_en);
            end
            tick();
        end
        checks++;
        if (instr_count !== 2'd1) begin
            errors++;
            $display("FAIL step_ignored_cnt got=%0d exp=1", instr_count);
        end
    endtask

    task automatic test_run_rate();
        do_reset();
        run_pulse = 1'b1;
        tick();
        run_pulse = 1'b0;
        checks++;
        if (running !== 1'b1 || cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL run_entry got run=%b en=%b exp run=1 en=0", running, cpu_en);
        end
        // Entry cycle holds divider 0; enables land every 10 cycles after it.
        for (int i = 1; i <= 34; i++) begin
            tick();
            checks++;
            if (cpu_en !== ((i % 10) == 0) || running !== 1'b1) begin
                errors++;
                $display("FAIL run_cycle_%0d got en=%b run=%b exp en=%b run=1", i, cpu_en, running, (i % 10) == 0);
            end
        end
        run_pulse = 1'b1;
        tick();
        run_pulse = 1'b0;
        checks++;
        if (running !== 1'b0 || instr_count !== 2'd3) begin
            errors++;
            $display("FAIL run_pause got run=%b cnt=%0d exp run=0 cnt=3", running, instr_count);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (cpu_en !== 1'b0) begin
                errors++;
                $display("FAIL paused_no_en_%0d got=%b exp=0", i, cpu_en);
            end
        end
    endtask

    task automatic test_pause_suppress();
        do_reset();
        run_pulse = 1'b1;
        tick();
        run_pulse = 1'b0;
        repeat (9) tick();
        run_pulse = 1'b1;
        tick();
        run_pulse = 1'b0;
        checks++;
        if (cpu_en !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_suppress got en=%b run=%b exp en=0 run=0", cpu_en, running);
        end
        tick();
        checks++;
        if (instr_count !== 2'd0) begin
            errors++;
            $display("FAIL pause_suppress_cnt got=%0d exp=0", instr_count);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        run_pulse  = 1'b1;
        step_pulse = 1'b1;
        tick();
        run_pulse  = 1'b0;
        step_pulse = 1'b0;
        checks++;
        if (cpu_en !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL simul_entry got en=%b run=%b exp en=0 run=1", cpu_en, running);
        end
        for (int i = 1; i <= 10; i++) begin
            step_pulse = (i == 3);
            tick();
            checks++;
            if (cpu_en !== (i == 10)) begin
                errors++;
                $display("FAIL simul_cycle_%0d got en=%b exp=%b", i, cpu_en, i == 10);
            end
        end
        step_pulse = 1'b0;
        tick();
        checks++;
        if (instr_count !== 2'd1) begin
            errors++;
            $display("FAIL simul_cnt got=%0d exp=1", instr_count);
        end
        run_pulse = 1'b1;
        tick();
        run_pulse = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        tick();
        run_pulse = 1'b1;
        tick();
        run_pulse = 1'b0;
        repeat (9) tick();
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        checks++;
        if (cpu_en !== 1'b0 || halted !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL halt_entry got en=%b halt=%b run=%b exp 0/1/0", cpu_en, halted, running);
        end
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        tick();
        run_pulse = 1'b1;
        tick();
        run_pulse = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (cpu_en !== 1'b0 || halted !== 1'b1 || running !== 1'b0 || instr_count !== 2'd1) begin
                errors++;
                $display("FAIL halt_hold_%0d got en=%b halt=%b run=%b cnt=%0d exp 0/1/0/1", i, cpu_en, halted, running, instr_count);
            end
        end
        do_reset();
        checks++;
        if (halted !== 1'b0 || instr_count !== 2'd0 || running !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset got halt=%b cnt=%0d run=%b exp 0/0/0", halted, instr_count, running);
        end
        // Halt beats a step pulse in the same cycle.
        halt_in    = 1'b1;
        step_pulse = 1'b1;
        tick();
        halt_in    = 1'b0;
        step_pulse = 1'b0;
        checks++;
        if (cpu_en !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_vs_step got en=%b halt=%b exp en=0 halt=1", cpu_en, halted);
        end
        do_reset();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int s = 0; s < 5; s++) begin
            step_pulse = 1'b1;
            tick();
            step_pulse = 1'b0;
            tick();
        end
        checks++;
        if (instr_count !== 2'd3) begin
            errors++;
            $display("FAIL saturate got=%0d exp=3", instr_count);
        end
    endtask

`ifdef BREAKPOINT_EN
    task automatic test_breakpoint();
        do_reset();
        bp_valid = 1'b1;
        bp_addr  = 8'h0C;
        pc       = 8'h0C;
        run_pulse = 1'b1;
        tick();
        run_pulse = 1'b0;
        repeat (9) tick();
        tick();
        checks++;
        if (cpu_en !== 1'b0 || bp_hit !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL bp_hit got en=%b hit=%b run=%b exp 0/1/0", cpu_en, bp_hit, running);
        end
        tick();
        checks++;
        if (bp_hit !== 1'b0) begin
            errors++;
            $display("FAIL bp_hit_pulse got=%b exp=0", bp_hit);
        end
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        checks++;
        if (cpu_en !== 1'b1) begin
            errors++;
            $display("FAIL bp_step got en=%b exp=1", cpu_en);
        end
        bp_valid = 1'b0;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        step_pulse = 1'b0;
        run_pulse  = 1'b0;
        halt_in    = 1'b0;
`ifdef BREAKPOINT_EN
        pc       = '0;
        bp_addr  = '0;
        bp_valid = 1'b0;
`endif
        test_reset();
        test_single_step();
        test_run_rate();
        test_pause_suppress();
        test_simultaneous();
        test_halt();
        test_saturate();
`ifdef BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
